// File: rtl/mem_bank_responder.sv
// ---------------------------------------------------------------------------
// mem_bank_responder
//
// One word-addressed 32-bit SRAM bank of the near-memory fabric. It answers
// the compute unit's read and write request interfaces one transaction at a
// time, and offers a debug backdoor for preload and inspection.
//
// Ports
//   clk, rstn          clock (rising edge) / asynchronous active-low reset
//   mem_read_req       read request level, held with mem_read_addr until
//                      mem_read_valid
//   mem_read_addr      32-bit word address of the read
//   mem_read_valid     one-cycle read response pulse
//   mem_read_data      read data; holds until the next read response
//   mem_write_req      write request level, held with addr/data until ack
//   mem_write_addr     32-bit word address of the write
//   mem_write_data     write data
//   mem_write_ack      one-cycle write response pulse
//   dbg_we             backdoor write enable
//   dbg_addr           backdoor word index (aw bits)
//   dbg_wdata          backdoor write data
//   dbg_rdata          array[dbg_addr], registered, one cycle of latency
//   busy               high whenever a transaction is in progress
//   err_oor            sticky out-of-range flag
//   clear_err          synchronous clear of err_oor (a new set wins)
//   rd_count           completed reads, saturating
//   wr_count           completed writes, saturating
// ---------------------------------------------------------------------------
module mem_bank_responder #(
    parameter int depth_words  = 16384,
    parameter int read_latency = 2,
    parameter int cnt_width    = 16,
    localparam int aw          = $clog2(depth_words)
) (
    input  logic                 clk,
    input  logic                 rstn,

    input  logic                 mem_read_req,
    input  logic [31:0]          mem_read_addr,
    output logic                 mem_read_valid,
    output logic [31:0]          mem_read_data,

    input  logic                 mem_write_req,
    input  logic [31:0]          mem_write_addr,
    input  logic [31:0]          mem_write_data,
    output logic                 mem_write_ack,

    input  logic                 dbg_we,
    input  logic [aw-1:0]        dbg_addr,
    input  logic [31:0]          dbg_wdata,
    output logic [31:0]          dbg_rdata,

    output logic                 busy,
    output logic                 err_oor,
    input  logic                 clear_err,
    output logic [cnt_width-1:0] rd_count,
    output logic [cnt_width-1:0] wr_count
);

    localparam int DATA_W = 32;
    // The wait counter holds at most read_latency-2 (cycles left after the
    // first READ_WAIT cycle).
    localparam int lw = (read_latency > 2) ? $clog2(read_latency - 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        READ_RESP,
        WRITE_RESP
    } state_t;

    state_t            state;
    logic              prefer_rd;
    logic [lw-1:0]     wait_cnt;
    logic              oor_p0;
    logic [DATA_W-1:0] rd_data_p0;
    logic [DATA_W-1:0] rd_hold;
    logic [DATA_W-1:0] dbg_rdata_p0;
    logic              dbg_vld_p0;

    logic [DATA_W-1:0] mem [depth_words];

    logic              rd_oor;
    logic              wr_oor;
    logic [aw-1:0]     rd_idx;
    logic [aw-1:0]     wr_idx;
    logic              accept_rd;
    logic              accept_wr;
    logic              wait_done;
    logic              err_set;

    function automatic logic [cnt_width-1:0] sat_inc(input logic [cnt_width-1:0] v);
        return (&v) ? v : v + cnt_width'(1);
    endfunction

    always_comb begin
        rd_oor    = (mem_read_addr  >= 32'(depth_words));
        wr_oor    = (mem_write_addr >= 32'(depth_words));
        rd_idx    = mem_read_addr[aw-1:0];
        wr_idx    = mem_write_addr[aw-1:0];
        // Pointer only matters when both requests are present; a lone request
        // always wins. Acceptance is blocked while reset is asserted so no
        // array write can slip in during reset.
        accept_rd = rstn && (state == IDLE) && mem_read_req &&
                    (!mem_write_req || prefer_rd);
        accept_wr = rstn && (state == IDLE) && mem_write_req && !accept_rd;
        wait_done = (state == READ_WAIT) && (wait_cnt == '0);
        // err_oor rises with the response pulse and is re-asserted at the end
        // of the response cycle, so a clear_err coinciding with the response
        // cannot drop it.
        err_set   = ((state == READ_RESP || state == WRITE_RESP) && oor_p0) ||
                    (accept_wr && wr_oor) ||
                    (accept_rd && rd_oor && (read_latency == 1)) ||
                    (wait_done && oor_p0);
    end

    // ---- stage p0: array access at the acceptance edge --------------------
    // The array is kept free of reset so it maps onto SRAM. The debug write
    // is issued last so it wins a same-index collision with an accepted write.
    always_ff @(posedge clk) begin
        if (accept_wr && !wr_oor) begin
            mem[wr_idx] <= mem_write_data;
        end
        if (dbg_we) begin
            mem[dbg_addr] <= dbg_wdata;
        end
        if (accept_rd) begin
            rd_data_p0 <= rd_oor ? '0 : mem[rd_idx];
        end
        dbg_rdata_p0 <= mem[dbg_addr];
    end

    // ---- control FSM, response pulses, flags and counters -----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            prefer_rd      <= 1'b1;
            wait_cnt       <= '0;
            oor_p0         <= 1'b0;
            rd_hold        <= '0;
            dbg_vld_p0     <= 1'b0;
            mem_read_valid <= 1'b0;
            mem_write_ack  <= 1'b0;
            err_oor        <= 1'b0;
            rd_count       <= '0;
            wr_count       <= '0;
        end else begin
            mem_read_valid <= 1'b0;
            mem_write_ack  <= 1'b0;
            dbg_vld_p0     <= 1'b1;

            case (state)
                IDLE: begin
                    if (accept_rd) begin
                        oor_p0    <= rd_oor;
                        prefer_rd <= 1'b0;
                        if (read_latency == 1) begin
                            state          <= READ_RESP;
                            mem_read_valid <= 1'b1;
                            rd_count       <= sat_inc(rd_count);
                        end else begin
                            state    <= READ_WAIT;
                            wait_cnt <= lw'(read_latency - 2);
                        end
                    end else if (accept_wr) begin
                        oor_p0        <= wr_oor;
                        prefer_rd     <= 1'b1;
                        state         <= WRITE_RESP;
                        mem_write_ack <= 1'b1;
                        wr_count      <= sat_inc(wr_count);
                    end
                end

                READ_WAIT: begin
                    if (wait_done) begin
                        state          <= READ_RESP;
                        mem_read_valid <= 1'b1;
                        rd_count       <= sat_inc(rd_count);
                    end else begin
                        wait_cnt <= wait_cnt - lw'(1);
                    end
                end

                READ_RESP: begin
                    // Requests seen during a response cycle are ignored.
                    state   <= IDLE;
                    rd_hold <= rd_data_p0;
                end

                WRITE_RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            if (err_set) begin
                err_oor <= 1'b1;
            end else if (clear_err) begin
                err_oor <= 1'b0;
            end
        end
    end

    // Outside a read response the last delivered word is shown, so the data
    // captured for an in-flight read never leaks out early.
    assign mem_read_data = (state == READ_RESP) ? rd_data_p0 : rd_hold;
    assign dbg_rdata     = dbg_vld_p0 ? dbg_rdata_p0 : '0;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mem_bank_responder.sv
module tb_mem_bank_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t a_rq[$];
    exp_t a_wq[$];
    exp_t b_rq[$];
    exp_t b_wq[$];

    // ---------------- instance A: read_latency=2, cnt_width=16 ----------------
    logic        a_rstn, a_rreq, a_rvalid, a_wreq, a_wack, a_dwe, a_busy, a_err, a_clr;
    logic [31:0] a_raddr, a_rdata, a_waddr, a_wdata, a_dwdata, a_drdata;
    logic [13:0] a_daddr;
    logic [15:0] a_rcnt, a_wcnt;

    mem_bank_responder #(.depth_words(16384), .read_latency(2), .cnt_width(16)) u_dut_a (
        .clk(clk), .rstn(a_rstn),
        .mem_read_req(a_rreq), .mem_read_addr(a_raddr),
        .mem_read_valid(a_rvalid), .mem_read_data(a_rdata),
        .mem_write_req(a_wreq), .mem_write_addr(a_waddr), .mem_write_data(a_wdata),
        .mem_write_ack(a_wack),
        .dbg_we(a_dwe), .dbg_addr(a_daddr), .dbg_wdata(a_dwdata), .dbg_rdata(a_drdata),
        .busy(a_busy), .err_oor(a_err), .clear_err(a_clr),
        .rd_count(a_rcnt), .wr_count(a_wcnt)
    );

    // ---------------- instance B: read_latency=4, cnt_width=3 -----------------
    logic        b_rstn, b_rreq, b_rvalid, b_wreq, b_wack, b_dwe, b_busy, b_err, b_clr;
    logic [31:0] b_raddr, b_rdata, b_waddr, b_wdata, b_dwdata, b_drdata;
    logic [13:0] b_daddr;
    logic [2:0]  b_rcnt, b_wcnt;

    mem_bank_responder #(.depth_words(16384), .read_latency(4), .cnt_width(3)) u_dut_b (
        .clk(clk), .rstn(b_rstn),
        .mem_read_req(b_rreq), .mem_read_addr(b_raddr),
        .mem_read_valid(b_rvalid), .mem_read_data(b_rdata),
        .mem_write_req(b_wreq), .mem_write_addr(b_waddr), .mem_write_data(b_wdata),
        .mem_write_ack(b_wack),
        .dbg_we(b_dwe), .dbg_addr(b_daddr), .dbg_wdata(b_dwdata), .dbg_rdata(b_drdata),
        .busy(b_busy), .err_oor(b_err), .clear_err(b_clr),
        .rd_count(b_rcnt), .wr_count(b_wcnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (a_rvalid === 1'b1) begin
            chk("a_rd_pending", 32'(a_rq.size() != 0), 32'd1);
            if (a_rq.size() != 0) begin
                chk("a_rd_data", a_rdata, a_rq[0].data);
                chk("a_rd_cycle", cyc, a_rq[0].cyc);
                void'(a_rq.pop_front());
            end
        end
        if (a_wack === 1'b1) begin
            chk("a_wr_pending", 32'(a_wq.size() != 0), 32'd1);
            if (a_wq.size() != 0) begin
                chk("a_wr_cycle", cyc, a_wq[0].cyc);
                void'(a_wq.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (b_rvalid === 1'b1) begin
            chk("b_rd_pending", 32'(b_rq.size() != 0), 32'd1);
            if (b_rq.size() != 0) begin
                chk("b_rd_data", b_rdata, b_rq[0].data);
                chk("b_rd_cycle", cyc, b_rq[0].cyc);
                void'(b_rq.pop_front());
            end
        end
        if (b_wack === 1'b1) begin
            chk("b_wr_pending", 32'(b_wq.size() != 0), 32'd1);
            if (b_wq.size() != 0) begin
                chk("b_wr_cycle", cyc, b_wq[0].cyc);
                void'(b_wq.pop_front());
            end
        end
    end

    // ---------------- stimulus helpers (called #1 after a rising edge) --------
    task automatic a_wait_rvalid();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (a_rvalid) return;
        end
        chk("a_rd_timeout", 32'(a_rvalid), 32'd1);
    endtask

    task automatic a_wait_wack();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (a_wack) return;
        end
        chk("a_wr_timeout", 32'(a_wack), 32'd1);
    endtask

    task automatic a_rd(input logic [31:0] addr, input logic [31:0] exp_data, input bit last);
        a_rreq  = 1'b1;
        a_raddr = addr;
        a_rq.push_back('{data: exp_data, cyc: cyc + 2});
        chk("a_busy_before_rd", 32'(a_busy), 32'd0);
        a_wait_rvalid();
        chk("a_busy_rd_resp", 32'(a_busy), 32'd1);
        @(posedge clk); #1;
        if (last) a_rreq = 1'b0;
    endtask

    task automatic a_wr(input logic [31:0] addr, input logic [31:0] data);
        a_wreq  = 1'b1;
        a_waddr = addr;
        a_wdata = data;
        a_wq.push_back('{data: 32'h0, cyc: cyc + 1});
        chk("a_busy_before_wr", 32'(a_busy), 32'd0);
        a_wait_wack();
        @(posedge clk); #1;
        a_wreq = 1'b0;
    endtask

    task automatic a_dbg_wr(input logic [13:0] addr, input logic [31:0] data);
        a_dwe = 1'b1; a_daddr = addr; a_dwdata = data;
        @(posedge clk); #1;
        a_dwe = 1'b0;
    endtask

    task automatic a_dbg_chk(input string name, input logic [13:0] addr, input logic [31:0] exp_data);
        a_daddr = addr;
        @(posedge clk); #1;
        chk(name, a_drdata, exp_data);
    endtask

    task automatic a_clear_pulse();
        a_clr = 1'b1;
        @(posedge clk); #1;
        a_clr = 1'b0;
    endtask

    task automatic b_wait_rvalid();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (b_rvalid) return;
        end
        chk("b_rd_timeout", 32'(b_rvalid), 32'd1);
    endtask

    task automatic b_wait_wack();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (b_wack) return;
        end
        chk("b_wr_timeout", 32'(b_wack), 32'd1);
    endtask

    task automatic b_rd(input logic [31:0] addr, input logic [31:0] exp_data);
        b_rreq  = 1'b1;
        b_raddr = addr;
        b_rq.push_back('{data: exp_data, cyc: cyc + 4});
        b_wait_rvalid();
        @(posedge clk); #1;
        b_rreq = 1'b0;
    endtask

    task automatic b_wr(input logic [31:0] addr, input logic [31:0] data);
        b_wreq  = 1'b1;
        b_waddr = addr;
        b_wdata = data;
        b_wq.push_back('{data: 32'h0, cyc: cyc + 1});
        b_wait_wack();
        @(posedge clk); #1;
        b_wreq = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t;
        a_rstn = 1'b0; a_rreq = 1'b0; a_raddr = '0; a_wreq = 1'b0; a_waddr = '0; a_wdata = '0;
        a_dwe = 1'b0; a_daddr = '0; a_dwdata = '0; a_clr = 1'b0;
        b_rstn = 1'b0; b_rreq = 1'b0; b_raddr = '0; b_wreq = 1'b0; b_waddr = '0; b_wdata = '0;
        b_dwe = 1'b0; b_daddr = '0; b_dwdata = '0; b_clr = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rvalid", 32'(a_rvalid), 32'd0);
        chk("rst_rdata",  a_rdata, 32'd0);
        chk("rst_wack",   32'(a_wack), 32'd0);
        chk("rst_drdata", a_drdata, 32'd0);
        chk("rst_busy",   32'(a_busy), 32'd0);
        chk("rst_err",    32'(a_err), 32'd0);
        chk("rst_rcnt",   32'(a_rcnt), 32'd0);
        chk("rst_wcnt",   32'(a_wcnt), 32'd0);
        a_rstn = 1'b1; b_rstn = 1'b1;
        @(posedge clk); #1;

        // Round trip and read-after-write.
        a_dbg_wr(14'd7, 32'h1122_3344);
        a_dbg_wr(14'd3, 32'h3333_3333);
        a_wr(32'd5, 32'hDEAD_BEEF);
        a_rd(32'd5, 32'hDEAD_BEEF, 1'b1);
        a_rd(32'd7, 32'h1122_3344, 1'b1);
        chk("t1_rcnt", 32'(a_rcnt), 32'd2);
        chk("t1_wcnt", 32'(a_wcnt), 32'd1);

        // Debug write collides with an accepted write to the same index.
        a_wreq = 1'b1; a_waddr = 32'd9; a_wdata = 32'h9999_0000;
        a_dwe = 1'b1; a_daddr = 14'd9; a_dwdata = 32'h1234_5678;
        a_wq.push_back('{data: 32'h0, cyc: cyc + 1});
        @(posedge clk); #1;
        a_dwe = 1'b0;
        @(posedge clk); #1;
        a_wreq = 1'b0;
        a_dbg_chk("dbg_wins", 14'd9, 32'h1234_5678);
        a_rd(32'd9, 32'h1234_5678, 1'b1);

        // Debug write during an in-flight read leaves the captured data alone.
        a_rreq = 1'b1; a_raddr = 32'd7;
        a_rq.push_back('{data: 32'h1122_3344, cyc: cyc + 2});
        @(posedge clk); #1;
        a_dwe = 1'b1; a_daddr = 14'd7; a_dwdata = 32'h7777_7777;
        @(posedge clk); #1;
        a_dwe = 1'b0;
        @(posedge clk); #1;
        a_rreq = 1'b0;
        a_rd(32'd7, 32'h7777_7777, 1'b1);

        // Reset, then simultaneous requests exercise the arbitration pointer.
        a_rstn = 1'b0;
        @(posedge clk); #1;
        a_rstn = 1'b1;
        @(posedge clk); #1;
        t = cyc;
        a_rreq = 1'b1; a_raddr = 32'd5;
        a_wreq = 1'b1; a_waddr = 32'd5; a_wdata = 32'hCAFE_F00D;
        a_rq.push_back('{data: 32'hDEAD_BEEF, cyc: t + 2});
        a_wq.push_back('{data: 32'h0,         cyc: t + 4});
        a_rq.push_back('{data: 32'hCAFE_F00D, cyc: t + 7});
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 5) a_wreq = 1'b0;
            if (k == 8) a_rreq = 1'b0;
        end
        chk("t2_rcnt", 32'(a_rcnt), 32'd2);
        chk("t2_wcnt", 32'(a_wcnt), 32'd1);

        // Back-to-back reads with req held high.
        a_dbg_wr(14'd100, 32'h0BAD_C0DE);
        a_rd(32'd5,   32'hCAFE_F00D, 1'b0);
        a_rd(32'd7,   32'h7777_7777, 1'b0);
        a_rd(32'd100, 32'h0BAD_C0DE, 1'b1);

        // Out of range handling.
        a_rd(32'd16384, 32'h0, 1'b1);
        chk("oor_rd_err", 32'(a_err), 32'd1);
        a_clear_pulse();
        chk("oor_clear1", 32'(a_err), 32'd0);
        a_wr(32'd16387, 32'h5555_5555);
        chk("oor_wr_err", 32'(a_err), 32'd1);
        a_dbg_chk("oor_scan3", 14'd3, 32'h3333_3333);
        a_dbg_chk("oor_scan5", 14'd5, 32'hCAFE_F00D);
        a_dbg_chk("oor_scan7", 14'd7, 32'h7777_7777);
        a_clear_pulse();
        chk("oor_clear2", 32'(a_err), 32'd0);
        a_rreq = 1'b1; a_raddr = 32'd20000;
        a_rq.push_back('{data: 32'h0, cyc: cyc + 2});
        @(posedge clk); #1;
        @(posedge clk); #1;
        a_clr = 1'b1;
        @(posedge clk); #1;
        a_clr = 1'b0; a_rreq = 1'b0;
        chk("oor_set_wins", 32'(a_err), 32'd1);
        chk("t4_rcnt", 32'(a_rcnt), 32'd7);
        chk("t4_wcnt", 32'(a_wcnt), 32'd2);

        // Instance B: reset while waiting for read data.
        b_dwe = 1'b1; b_daddr = 14'd5; b_dwdata = 32'hA5A5_0005;
        @(posedge clk); #1;
        b_dwe = 1'b0;
        b_rreq = 1'b1; b_raddr = 32'd5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_rstn = 1'b0; b_rreq = 1'b0;
        #1;
        chk("b_rst_rvalid", 32'(b_rvalid), 32'd0);
        chk("b_rst_rdata",  b_rdata, 32'd0);
        chk("b_rst_wack",   32'(b_wack), 32'd0);
        chk("b_rst_drdata", b_drdata, 32'd0);
        chk("b_rst_busy",   32'(b_busy), 32'd0);
        chk("b_rst_err",    32'(b_err), 32'd0);
        chk("b_rst_rcnt",   32'(b_rcnt), 32'd0);
        chk("b_rst_wcnt",   32'(b_wcnt), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        b_rstn = 1'b1;
        @(posedge clk); #1;
        b_rd(32'd5, 32'hA5A5_0005);
        chk("b_rcnt", 32'(b_rcnt), 32'd1);

        // Instance B: write counter saturates at 7.
        for (int i = 1; i <= 9; i++) begin
            b_wr(32'(200 + i), 32'(i));
            chk("b_wcnt_sat", 32'(b_wcnt), (i < 7) ? 32'(i) : 32'd7);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("a_rq_drained", 32'(a_rq.size()), 32'd0);
        chk("a_wq_drained", 32'(a_wq.size()), 32'd0);
        chk("b_rq_drained", 32'(b_rq.size()), 32'd0);
        chk("b_wq_drained", 32'(b_wq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/mem_bank_responder.md
Name: mem_bank_responder

Overview:
- Memory-side responder for the compute unit's memory read and write request interfaces. It is one word-addressed SRAM bank of the near-memory fabric.
- It serves one transaction at a time from the compute unit: one read or one write.
- A debug backdoor port gives the host and bench preload and inspection access.
- Saturating transaction counters and a sticky out-of-range error flag are provided.

Parameters:
- depth_words, 16384, number of 32-bit words in the bank; power of 2; index width aw = log2(depth_words).
- read_latency, 2, cycles from read acceptance to the mem_read_valid pulse; must be ≥ 1.
- cnt_width, 16, width of the transaction counters.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- mem_read_req  input  1  read request, level; held with addr until mem_read_valid.
- mem_read_addr  input  32  word address.
- mem_read_valid  output  1  one-cycle read response pulse.
- mem_read_data  output  32  read data; valid when mem_read_valid=1.
- mem_write_req  input  1  write request, level; held with addr/data until mem_write_ack.
- mem_write_addr  input  32  word address.
- mem_write_data  input  32  write data.
- mem_write_ack  output  1  one-cycle write response pulse.
- dbg_we  input  1  backdoor write enable.
- dbg_addr  input  aw  backdoor address.
- dbg_wdata  input  32  backdoor write data.
- dbg_rdata  output  32  backdoor read data; registered, 1-cycle latency.
- busy  output  1  high when state != IDLE.
- err_oor  output  1  sticky out-of-range flag.
- clear_err  input  1  synchronous clear of err_oor.
- rd_count  output  cnt_width  completed reads; saturating.
- wr_count  output  cnt_width  completed writes; saturating.

Behaviour:
- Reset values: all outputs 0 and state IDLE. The arbitration pointer favours read. Array contents are not reset.
- States:
  - IDLE: accept a request.
  - READ_WAIT: count read_latency-1 cycles; skipped when read_latency=1.
  - READ_RESP: mem_read_valid=1 for this cycle only.
  - WRITE_RESP: mem_write_ack=1 for this cycle only.
  - Both response states return to IDLE.
- Acceptance: a request is accepted in IDLE on the edge at the end of cycle T where its req=1.
- Read timing: the array is read at acceptance and the data is registered. mem_read_valid is high in cycle T+read_latency only. mem_read_data holds its value until the next read response.
- Write timing: the array is written at the acceptance edge. mem_write_ack is high in cycle T+1 only.
- Throughput: the earliest next acceptance is on the edge ending the response cycle (back-to-back). Reads are spaced read_latency+1 cycles; writes 2 cycles.
- Initiator side: req sampled high in the response cycle is ignored. The initiator drops req or presents a new request in the following cycle, and that cycle is treated as a fresh request.
- Arbitration: when both req are high in IDLE, the request favoured by the pointer wins and the pointer flips to the other type. A lone request is accepted regardless of the pointer, and the pointer then favours the other type.
- Read-after-write: a read accepted after a write ack returns the new data.
- Out of range: an address is out of range when address ≥ depth_words.
  - Read: returns 0.
  - Write: not applied to the array, but still acked.
  - Both set err_oor in the response cycle.
- err_oor clearing: clear_err=1 clears err_oor. If clear_err and a new OOR response occur in the same cycle, set wins.
- Counters: rd_count increments on each mem_read_valid pulse and wr_count on each mem_write_ack pulse. Both saturate at all-ones and do not wrap. OOR transactions are counted.
- Debug port:
  - dbg_rdata = array[dbg_addr] registered every cycle.
  - dbg_we writes on the edge. If dbg_we and an accepted write target the same index on the same edge, the dbg write wins.
  - A debug write to the address of an in-flight read does not alter the already-registered read data.
- Reset mid-operation: an in-flight transaction is dropped and no response pulse is produced. The initiator reissues after reset. A write accepted before reset remains in the array.
- X handling: mem_read_addr and mem_write_addr/data are don't-care while the matching req=0.

Test Plan:
- Write/read round trip, read_latency=2: dbg-preload addr 7=0x11223344. Write 0xDEADBEEF to addr 5 -> ack high in exactly T+1. Read addr 5 -> valid in exactly T+2 with data 0xDEADBEEF. Read addr 7 -> 0x11223344. rd_count=2, wr_count=1.
- Simultaneous requests after reset: read addr 5 and write addr 5=0xCAFEF00D -> read served first, returning the old value, then the write is acked. Repeat both -> write first, and the read returns 0xCAFEF00D.
- Back-to-back reads: read_req held with 3 addresses, each changed in the cycle after valid -> valid pulses spaced 3 cycles apart, each 1 cycle wide, with correct data. busy is low only in the acceptance cycles' preceding IDLE.
- Out of range: read addr 16384 -> data 0, err_oor=1. Write addr 16387 -> acked, dbg scan shows no array change. Pulse clear_err -> err_oor=0. Assert clear_err during an OOR response -> err_oor=1.
- Reset in READ_WAIT, read_latency=4: assert rstn=0 at T+2 -> valid never pulses and all outputs are 0. After release, read addr 5 -> correct response.
- Counter saturation with cnt_width=3: perform 9 writes -> wr_count reaches 7 and stays 7.
